// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c command sequencer: core register map, STATUS bits,
// response codes and the state/operation encodings used by the sequencer and its bus engine.
package i2c_pkg;

    localparam logic [2:0] REG_PERIOD  = 3'd0;
    localparam logic [2:0] REG_TX      = 3'd1;
    localparam logic [2:0] REG_RX      = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_I2CADDR = 3'd4;

    localparam int ST_START     = 0;
    localparam int ST_STOP      = 1;
    localparam int ST_WRITE_EN  = 2;
    localparam int ST_WRITE_ACK = 3;
    localparam int ST_READ_EN   = 4;
    localparam int ST_READ_ACK  = 5;
    localparam int ST_RESET     = 6;

    localparam logic [7:0] STAT_START_WR = 8'h05;
    localparam logic [7:0] STAT_WR       = 8'h04;
    localparam logic [7:0] STAT_RD       = 8'h10;
    localparam logic [7:0] STAT_STOP     = 8'h02;
    localparam logic [7:0] STAT_RESET    = 8'h40;

    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_ADDR_NACK = 2'b01;
    localparam logic [1:0] ERR_DATA_NACK = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

    typedef enum logic [1:0] {OP_NONE, OP_WR, OP_RD, OP_POLL} bus_op_e;

    typedef enum logic [1:0] {B_IDLE, B_RD, B_SAMP} bus_state_e;

    typedef enum logic [4:0] {
        S_IDLE, S_CFG, S_ADDR, S_START, S_WAIT_START,
        S_TXREG, S_REGGO, S_WAIT_REG, S_TXDATA, S_DATAGO, S_WAIT_DATA,
        S_RADDR, S_RSTART, S_WAIT_RSTART, S_RDGO, S_WAIT_RD, S_RDRX,
        S_STOP, S_WAIT_STOP, S_DONE
    } seq_state_e;

    // The first error of a command is the one reported.
    function automatic logic [1:0] merge_err(input logic [1:0] cur, input logic [1:0] nxt);
        return (cur == ERR_OK) ? nxt : cur;
    endfunction

endpackage

// File: rtl/i2c_seq_bus.sv
// Core register bus engine: single writes, single reads, and STATUS polling until a mask
// clears, with a per-poll cycle limit that resets the core on expiry.
module i2c_seq_bus
    import i2c_pkg::*;
#(
    parameter int          ADDR_W  = 3,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  bus_op_e           op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    input  logic [7:0]        mask,
    output logic              done,
    output logic              tmo,
    output logic [7:0]        rdata,
    output logic [ADDR_W-1:0] i2c_addr,
    output logic [7:0]        i2c_din,
    output logic              i2c_wren,
    output logic              i2c_rden,
    input  logic [7:0]        i2c_dout
);

    bus_state_e  bst;
    logic        polling;
    logic [15:0] tcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bst      <= B_IDLE;
            polling  <= 1'b0;
            tcnt     <= 16'd0;
            done     <= 1'b0;
            tmo      <= 1'b0;
            rdata    <= 8'h00;
            i2c_addr <= '0;
            i2c_din  <= 8'h00;
            i2c_wren <= 1'b0;
            i2c_rden <= 1'b0;
        end else begin
            done     <= 1'b0;
            tmo      <= 1'b0;
            i2c_wren <= 1'b0;
            case (bst)
                B_IDLE: begin
                    if (go && op == OP_WR) begin
                        i2c_addr <= addr;
                        i2c_din  <= wdata;
                        i2c_wren <= 1'b1;
                        done     <= 1'b1;
                    end else if (go && (op == OP_RD || op == OP_POLL)) begin
                        i2c_addr <= addr;
                        i2c_rden <= 1'b1;
                        polling  <= (op == OP_POLL);
                        tcnt     <= 16'd0;
                        bst      <= B_RD;
                    end
                end
                B_RD: begin
                    i2c_rden <= 1'b0;
                    tcnt     <= tcnt + 16'd1;
                    bst      <= B_SAMP;
                end
                B_SAMP: begin
                    // read data is valid the cycle after the strobe
                    rdata <= i2c_dout;
                    tcnt  <= tcnt + 16'd1;
                    if (!polling || (i2c_dout & mask) == 8'h00) begin
                        done <= 1'b1;
                        bst  <= B_IDLE;
                    end else if (tcnt >= TIMEOUT - 16'd1) begin
                        i2c_addr <= ADDR_W'(REG_STATUS);
                        i2c_din  <= STAT_RESET;
                        i2c_wren <= 1'b1;
                        done     <= 1'b1;
                        tmo      <= 1'b1;
                        bst      <= B_IDLE;
                    end else begin
                        i2c_rden <= 1'b1;
                        bst      <= B_RD;
                    end
                end
                default: bst <= B_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/i2c_seq.sv
// Command-level i2c sequencer: turns one register write/read command into the full
// START/address/register/data/STOP series of core register accesses.
module i2c_seq
    import i2c_pkg::*;
#(
    parameter logic [7:0]  PERIOD  = 8'd250,
    parameter logic [15:0] TIMEOUT = 16'd50000,
    parameter int          ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [6:0]        cmd_dev,
    input  logic [7:0]        cmd_reg,
    input  logic [7:0]        cmd_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] i2c_addr,
    output logic [7:0]        i2c_din,
    output logic              i2c_wren,
    output logic              i2c_rden,
    input  logic [7:0]        i2c_dout
);

    seq_state_e        state;
    logic              issued;
    logic              go;
    logic              accept;
    logic              rw_q;
    logic [6:0]        dev_q;
    logic [7:0]        reg_q;
    logic [7:0]        wdata_q;
    bus_op_e           req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_data;
    logic [7:0]        req_mask;
    logic              bus_done;
    logic              bus_tmo;
    logic [7:0]        bus_rdata;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (accept) begin
            rw_q    <= cmd_rw;
            dev_q   <= cmd_dev;
            reg_q   <= cmd_reg;
            wdata_q <= cmd_wdata;
        end
    end

    // Each phase state maps to exactly one bus operation.
    always_comb begin
        req_op   = OP_NONE;
        req_addr = '0;
        req_data = 8'h00;
        req_mask = 8'h00;
        case (state)
            S_CFG:         begin req_op = OP_WR; req_addr = ADDR_W'(REG_PERIOD);  req_data = PERIOD;          end
            S_ADDR:        begin req_op = OP_WR; req_addr = ADDR_W'(REG_I2CADDR); req_data = {dev_q, 1'b0};  end
            S_RADDR:       begin req_op = OP_WR; req_addr = ADDR_W'(REG_I2CADDR); req_data = {dev_q, 1'b1};  end
            S_START,
            S_RSTART:      begin req_op = OP_WR; req_addr = ADDR_W'(REG_STATUS);  req_data = STAT_START_WR;  end
            S_TXREG:       begin req_op = OP_WR; req_addr = ADDR_W'(REG_TX);      req_data = reg_q;          end
            S_TXDATA:      begin req_op = OP_WR; req_addr = ADDR_W'(REG_TX);      req_data = wdata_q;        end
            S_REGGO,
            S_DATAGO:      begin req_op = OP_WR; req_addr = ADDR_W'(REG_STATUS);  req_data = STAT_WR;        end
            S_RDGO:        begin req_op = OP_WR; req_addr = ADDR_W'(REG_STATUS);  req_data = STAT_RD;        end
            S_STOP:        begin req_op = OP_WR; req_addr = ADDR_W'(REG_STATUS);  req_data = STAT_STOP;      end
            S_RDRX:        begin req_op = OP_RD; req_addr = ADDR_W'(REG_RX);                                 end
            S_WAIT_START,
            S_WAIT_RSTART: begin req_op = OP_POLL; req_addr = ADDR_W'(REG_STATUS); req_mask = STAT_START_WR; end
            S_WAIT_REG,
            S_WAIT_DATA:   begin req_op = OP_POLL; req_addr = ADDR_W'(REG_STATUS); req_mask = STAT_WR;       end
            S_WAIT_RD:     begin req_op = OP_POLL; req_addr = ADDR_W'(REG_STATUS); req_mask = STAT_RD;       end
            S_WAIT_STOP:   begin req_op = OP_POLL; req_addr = ADDR_W'(REG_STATUS); req_mask = STAT_STOP;     end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= ERR_OK;
            issued    <= 1'b0;
            go        <= 1'b0;
        end else begin
            go        <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        rsp_err   <= ERR_OK;
                        rsp_rdata <= 8'h00;
                        state     <= S_CFG;
                    end
                end
                S_DONE: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    if (!issued) begin
                        go     <= 1'b1;
                        issued <= 1'b1;
                    end else if (bus_done) begin
                        issued <= 1'b0;
                        if (bus_tmo) begin
                            // the core has already been reset, so no STOP follows
                            rsp_err   <= ERR_TIMEOUT;
                            rsp_rdata <= 8'h00;
                            rsp_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            case (state)
                                S_CFG:    state <= S_ADDR;
                                S_ADDR:   state <= S_START;
                                S_START:  state <= S_WAIT_START;
                                S_WAIT_START: begin
                                    if (bus_rdata[ST_WRITE_ACK]) state <= S_TXREG;
                                    else begin
                                        rsp_err <= merge_err(rsp_err, ERR_ADDR_NACK);
                                        state   <= S_STOP;
                                    end
                                end
                                S_TXREG:  state <= S_REGGO;
                                S_REGGO:  state <= S_WAIT_REG;
                                S_WAIT_REG: begin
                                    if (!bus_rdata[ST_WRITE_ACK]) begin
                                        rsp_err <= merge_err(rsp_err, ERR_DATA_NACK);
                                        state   <= S_STOP;
                                    end else begin
                                        state <= rw_q ? S_RADDR : S_TXDATA;
                                    end
                                end
                                S_TXDATA: state <= S_DATAGO;
                                S_DATAGO: state <= S_WAIT_DATA;
                                S_WAIT_DATA: begin
                                    if (!bus_rdata[ST_WRITE_ACK])
                                        rsp_err <= merge_err(rsp_err, ERR_DATA_NACK);
                                    state <= S_STOP;
                                end
                                S_RADDR:  state <= S_RSTART;
                                S_RSTART: state <= S_WAIT_RSTART;
                                S_WAIT_RSTART: begin
                                    if (bus_rdata[ST_WRITE_ACK]) state <= S_RDGO;
                                    else begin
                                        rsp_err <= merge_err(rsp_err, ERR_ADDR_NACK);
                                        state   <= S_STOP;
                                    end
                                end
                                S_RDGO:    state <= S_WAIT_RD;
                                S_WAIT_RD: state <= S_RDRX;
                                S_RDRX: begin
                                    rsp_rdata <= bus_rdata;
                                    state     <= S_STOP;
                                end
                                S_STOP:    state <= S_WAIT_STOP;
                                S_WAIT_STOP: begin
                                    rsp_valid <= 1'b1;
                                    state     <= S_DONE;
                                end
                                default:   state <= S_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    i2c_seq_bus #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_bus (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .op       (req_op),
        .addr     (req_addr),
        .wdata    (req_data),
        .mask     (req_mask),
        .done     (bus_done),
        .tmo      (bus_tmo),
        .rdata    (bus_rdata),
        .i2c_addr (i2c_addr),
        .i2c_din  (i2c_din),
        .i2c_wren (i2c_wren),
        .i2c_rden (i2c_rden),
        .i2c_dout (i2c_dout)
    );

endmodule

// File: doc/i2c_seq.md
Name: i2c_seq

Overview:
Command-level sequencer for the i2c register-mapped core. It accepts one "write byte to device register" or "read byte from device register" command. It then issues the register writes, reads and status polls on the core's register bus that perform the full START/address/register/data/STOP transfer. It sits between system logic (or a microcontroller) and the i2c core, which is the only thing that drives the core's bus.

Parameters:
PERIOD, 8'd250, value written to PERIOD_REG before every command (SCL half-period divisor)
TIMEOUT, 16'd50000, max clk cycles spent polling any single phase before aborting
ADDR_W, 3, width of core register address (PERIOD=0, TX=1, RX=2, STATUS=3, I2CADDR=4)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE; command accepted when cmd_valid & cmd_ready
cmd_rw  in  1  0 = write, 1 = read
cmd_dev  in  7  7-bit slave address
cmd_reg  in  8  slave register index
cmd_wdata  in  8  write data (ignored for reads)
rsp_valid  out  1  one-cycle pulse: command finished
rsp_rdata  out  8  read byte, valid with rsp_valid for reads; 0 for writes/errors
rsp_err  out  2  00 ok, 01 address NACK, 10 data/register NACK, 11 timeout
busy  out  1  high from acceptance until rsp_valid cycle inclusive
i2c_addr  out  ADDR_W  core register address
i2c_din  out  8  core write data
i2c_wren  out  1  core register write strobe (one cycle per write)
i2c_rden  out  1  core register read strobe
i2c_dout  in  8  core read data, valid the cycle after i2c_rden

Behaviour:
- Reset (async, reset=0): state IDLE, cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, i2c_wren=0, i2c_rden=0, i2c_addr=0, i2c_din=0, timeout counter=0.
- Command fields are latched on acceptance; later input changes are ignored. No new command is accepted while busy.
- Core bus: a write is one cycle with wren=1 and addr/din valid. A read is rden=1 for one cycle; dout is sampled the next cycle. wren and rden are never high together.
- STATUS bit map: 0 START, 1 STOP, 2 WRITE_EN, 3 WRITE_ACK (1 = slave ACKed), 4 READ_EN, 5 READ_ACK (ACK to send after read; 0 = NACK), 6 RESET. The core clears 0/1/2/4 when each phase completes.
- Poll (WAIT_x states): read STATUS, sample, repeat every 2 cycles until the commanded bits read 0. The timeout counter clears on entry to each WAIT state. At TIMEOUT cycles: write STATUS=0x40 (RESET), then rsp_err=11.
- Sequence, one core write per state:
  - CFG: PERIOD_REG <= PERIOD.
  - ADDR: I2CADDR <= {dev,0}.
  - Send START: STATUS <= 0x05 (START|WRITE_EN), WAIT; WRITE_ACK=0 -> STOP path with err 01.
  - Send register: TX <= reg, STATUS <= 0x04, WAIT; NACK -> STOP path with err 10.
  - Write command: TX <= wdata, STATUS <= 0x04, WAIT; NACK -> err 10; then STOP.
  - Read command: I2CADDR <= {dev,1}, STATUS <= 0x05 (repeated start), WAIT; NACK -> err 01. Then STATUS <= 0x10 (READ_EN, READ_ACK=0), WAIT, read RX_REG, latch byte; then STOP.
  - STOP: STATUS <= 0x02, WAIT (timeout -> err 11 overrides), then DONE.
- DONE: rsp_valid=1 for one cycle with rsp_rdata/rsp_err, busy still 1. Next cycle IDLE, cmd_ready=1. A command presented in that IDLE cycle is accepted immediately.
- Error latching: the first error wins, except that a timeout always reports 11.
- Reset mid-command: everything returns to reset values; no STOP is issued (the core is reset by the same line).

Decomposition:
- Shared package i2c_pkg: register addresses (PERIOD/TX/RX/STATUS/I2CADDR), STATUS bit indices, error code constants, state enum.
- One sub-module, i2c_seq_bus: it issues single reads and writes and polls STATUS until a mask clears, returning done/timeout. The top FSM sequences phases only.

Test Plan:
- Write dev=0x50 reg=0x10 data=0xA5, BFM ACKs all -> core writes in order PERIOD=250, I2CADDR=0xA0, STATUS=0x05, TX=0x10, STATUS=0x04, TX=0xA5, STATUS=0x04, STATUS=0x02; rsp_err=00.
- Read dev=0x50 reg=0x20, BFM RX=0x3C -> I2CADDR 0xA0 then 0xA1, STATUS=0x10, RX read; rsp_rdata=0x3C, rsp_err=00.
- Address NACK (WRITE_ACK=0 after first byte) -> STOP issued, no TX data write, rsp_err=01, rsp_rdata=0.
- BFM never clears WRITE_EN, TIMEOUT=100 -> STATUS=0x40 written between cycles 100 and 102 of polling; rsp_err=11, no STOP write.
- Back-to-back: cmd_valid held high over 2 writes -> second accepted the cycle after rsp_valid; cmd_ready=0 throughout the first.
- Assert reset mid-poll -> all outputs are at reset values in the same cycle; the next command runs normally.
